// File: rtl/divider_pkg.sv
// Shared constants for the restoring divider: state encoding, operand width and result field offsets.
package divider_pkg;

    localparam int DIV_WIDTH = 32;

    // result = {remainder, quotient}
    localparam int HI_LSB = 32;
    localparam int LO_LSB = 0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/divider_if.sv
// Request/response bundle between the execute stage and the divider.
// DIVIDER_ZERO_FLAG_EN adds the div_zero response flag.
interface divider_if
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);

    logic               start;
    logic               sign;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               annul;
    logic               stall;
    logic               ready;
    logic [2*WIDTH-1:0] result;
`ifdef DIVIDER_ZERO_FLAG_EN
    logic               div_zero;
`endif

`ifdef DIVIDER_ZERO_FLAG_EN
    modport master (
        output start, sign, a, b, annul,
        input  stall, ready, result, div_zero
    );

    modport slave (
        input  start, sign, a, b, annul,
        output stall, ready, result, div_zero
    );
`else
    modport master (
        output start, sign, a, b, annul,
        input  stall, ready, result
    );

    modport slave (
        input  start, sign, a, b, annul,
        output stall, ready, result
    );
`endif

endinterface

// File: rtl/divider_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial remainder and try to subtract.
module div_step
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] trial;

    assign trial = {rem_in, bit_in};
    assign q_bit = (trial >= {1'b0, divisor});

    // When the subtraction succeeds the true difference is below the divisor, so WIDTH bits are enough.
    assign rem_out = q_bit ? (trial[WIDTH-1:0] - divisor) : trial[WIDTH-1:0];

endmodule

// File: rtl/divider.sv
// Multi-cycle restoring divider for div/divu; one quotient bit per cycle, stalls the pipeline while busy.
// Define DIVIDER_ZERO_FLAG_EN to add a div_zero flag reported alongside ready.
module divider
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input logic      clk,
    input logic      rst,
    divider_if.slave bus
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [1:0]         state_q,  state_d;
    logic [WIDTH-1:0]   dvd_q,    dvd_d;
    logic [WIDTH-1:0]   dvs_q,    dvs_d;
    logic [WIDTH-1:0]   rem_q,    rem_d;
    logic [CW-1:0]      cnt_q,    cnt_d;
    logic               q_neg_q,  q_neg_d;
    logic               r_neg_q,  r_neg_d;
    logic               signed_q, signed_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    logic               accept;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH-1:0]   step_rem;
    logic               step_bit;
    logic [WIDTH-1:0]   quo_raw;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

`ifdef DIVIDER_ZERO_FLAG_EN
    logic               zero_q,   zero_d;
`endif

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in  (rem_q),
        .bit_in  (dvd_q[WIDTH-1]),
        .divisor (dvs_q),
        .rem_out (step_rem),
        .q_bit   (step_bit)
    );

    assign accept = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && bus.start && !bus.annul;

    assign abs_a = (bus.sign && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign abs_b = (bus.sign && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    // The dividend register shifts out dividend bits at the top while quotient bits fill in from below.
    assign quo_raw = {dvd_q[WIDTH-2:0], step_bit};
    assign quo_fix = (signed_q && q_neg_q) ? -quo_raw : quo_raw;
    assign rem_fix = (signed_q && r_neg_q) ? -step_rem : step_rem;

    always_comb begin
        state_d  = state_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        signed_d = signed_q;
        result_d = result_q;
`ifdef DIVIDER_ZERO_FLAG_EN
        zero_d   = zero_q;
`endif

        if (bus.annul) begin
            state_d = ST_IDLE;
        end else if (accept) begin
            state_d  = ST_BUSY;
            dvd_d    = abs_a;
            dvs_d    = abs_b;
            rem_d    = '0;
            cnt_d    = CW'(WIDTH);
            q_neg_d  = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            r_neg_d  = bus.a[WIDTH-1];
            signed_d = bus.sign;
`ifdef DIVIDER_ZERO_FLAG_EN
            zero_d   = (bus.b == '0);
`endif
        end else begin
            case (state_q)
                ST_BUSY: begin
                    dvd_d = quo_raw;
                    rem_d = step_rem;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d  = ST_DONE;
                        result_d = {rem_fix, quo_fix};
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            signed_q <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            signed_q <= signed_d;
            result_q <= result_d;
        end
    end

`ifdef DIVIDER_ZERO_FLAG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_q <= 1'b0;
        end else begin
            zero_q <= zero_d;
        end
    end

    assign bus.div_zero = (state_q == ST_DONE) && zero_q;
`endif

    // Stall covers the accepting cycle too, so the stage holds until the result is ready.
    assign bus.stall  = accept || ((state_q == ST_BUSY) && !bus.annul);
    assign bus.ready  = (state_q == ST_DONE);
    assign bus.result = result_q;

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: directed divides push expected results, a negedge monitor pops and compares on ready.
module tb_divider;
    import divider_pkg::*;

    typedef struct {
        logic [2*DIV_WIDTH-1:0] res;
        logic                   zf;
        int                     due;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   stall_cnt = 0;
    int   ready_cnt = 0;
    exp_t sb[$];

    divider_if #(.WIDTH(DIV_WIDTH)) bus();

    divider #(
        .WIDTH (DIV_WIDTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic noteFail(input string name);
        n_checks++;
        $display("[TB] FAIL %s: got event expected none", name);
    endtask

    // Drive a request for one cycle; if a completion is expected, queue its result and due cycle.
    task automatic applyStimulus(input logic sg, input logic [31:0] av, input logic [31:0] bv,
                                 input logic [63:0] exp, input logic zf, input bit expect_done);
        exp_t e;
        bus.start = 1'b1;
        bus.sign  = sg;
        bus.a     = av;
        bus.b     = bv;
        if (expect_done) begin
            e.res = exp;
            e.zf  = zf;
            e.due = cyc + DIV_WIDTH + 1;
            sb.push_back(e);
        end
        @(posedge clk);
        #2;
        bus.start = 1'b0;
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            noteFail("drain_timeout");
            sb.delete();
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            stall_cnt += int'(bus.stall);
            ready_cnt += int'(bus.ready);
            if (bus.ready === 1'b1) begin
                if (sb.size() == 0) begin
                    noteFail("unexpected_ready");
                end else begin
                    e = sb.pop_front();
                    checkOutput("result", bus.result, e.res);
                    checkOutput("ready_cycle", 64'(cyc), 64'(e.due));
`ifdef DIVIDER_ZERO_FLAG_EN
                    checkOutput("div_zero", 64'(bus.div_zero), 64'(e.zf));
`endif
                end
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.sign  = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.annul = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checkOutput("reset_ready", 64'(bus.ready), 64'd0);
        checkOutput("reset_stall", 64'(bus.stall), 64'd0);
        checkOutput("reset_result", bus.result, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #2;

        $display("[TB] divu 100/7");
        stall_cnt = 0;
        ready_cnt = 0;
        applyStimulus(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, 1'b1);
        waitDrain();
        checkOutput("stall_cycles", 64'(stall_cnt), 64'd33);
        checkOutput("ready_cycles", 64'(ready_cnt), 64'd1);

        $display("[TB] signed divides");
        applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0, 1'b1);
        waitDrain();
        applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 1'b0, 1'b1);
        waitDrain();

        $display("[TB] divide by zero");
        applyStimulus(1'b0, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, 1'b1, 1'b1);
        waitDrain();

        $display("[TB] back-to-back");
        stall_cnt = 0;
        ready_cnt = 0;
        applyStimulus(1'b0, 32'd1000, 32'd10, {32'd0, 32'd100}, 1'b0, 1'b1);
        repeat (DIV_WIDTH) @(posedge clk);
        #2;
        applyStimulus(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 1'b0, 1'b1);
        waitDrain();
        checkOutput("b2b_stall_cycles", 64'(stall_cnt), 64'd66);
        checkOutput("b2b_ready_cycles", 64'(ready_cnt), 64'd2);

        $display("[TB] annul");
        ready_cnt = 0;
        applyStimulus(1'b0, 32'd1000, 32'd3, 64'd0, 1'b0, 1'b0);
        repeat (9) @(posedge clk);
        #2;
        bus.annul = 1'b1;
        #1;
        checkOutput("annul_stall", 64'(bus.stall), 64'd0);
        @(posedge clk);
        #2;
        bus.annul = 1'b0;
        #1;
        checkOutput("annul_idle_stall", 64'(bus.stall), 64'd0);
        @(posedge clk);
        #2;
        applyStimulus(1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 1'b0, 1'b1);
        waitDrain();
        checkOutput("annul_ready_cycles", 64'(ready_cnt), 64'd1);

        $display("[TB] reset mid-busy");
        applyStimulus(1'b1, 32'hFFFF_FF9C, 32'd7, 64'd0, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_ready", 64'(bus.ready), 64'd0);
        checkOutput("midrst_stall", 64'(bus.stall), 64'd0);
        checkOutput("midrst_result", bus.result, 64'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #2;
        applyStimulus(1'b0, 32'hFFFF_FFFF, 32'd16, {32'hF, 32'h0FFF_FFFF}, 1'b0, 1'b1);
        waitDrain();
        applyStimulus(1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 1'b0, 1'b1);
        waitDrain();
        applyStimulus(1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, {32'hFFFF_FFFE, 32'd2}, 1'b0, 1'b1);
        waitDrain();

        repeat (3) @(posedge clk);
        #2;
        checkOutput("result_hold", bus.result, {32'hFFFF_FFFE, 32'd2});

        if (sb.size() != 0) noteFail("scoreboard_leftover");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
